// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//   - WIDTH / NREGS / AW : datapath width, register count, register address width
//   - OP_*               : ALU opcodes
//   - state_e            : sequencer FSM encoding
//   - op_sets_carry()    : whether an opcode produces a meaningful carry
package alu_pkg;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREGS = 8;
   localparam int unsigned AW    = $clog2(NREGS);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_e;

   // The ALU leaves C undefined for shifts/rotates, so those must not touch flagC.
   function automatic logic op_sets_carry(input logic [2:0] op);
      return !((op == OP_SHL) || (op == OP_ROR));
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command handshake bundle between a host and the sequencer.
//   cmdValid  host -> seq  command present
//   cmdReady  seq -> host  command accepted on a clock edge where both are high
//   cmdOp     host -> seq  ALU opcode
//   cmdSrcA/cmdSrcB/cmdDst host -> seq register indices
// Modports: master (host side), slave (sequencer side).
interface alu_sequencer_if;
   import alu_pkg::*;

   logic          cmdValid;
   logic          cmdReady;
   logic [2:0]    cmdOp;
   logic [AW-1:0] cmdSrcA;
   logic [AW-1:0] cmdSrcB;
   logic [AW-1:0] cmdDst;

   modport master (
      output cmdValid, cmdOp, cmdSrcA, cmdSrcB, cmdDst,
      input  cmdReady
   );

   modport slave (
      input  cmdValid, cmdOp, cmdSrcA, cmdSrcB, cmdDst,
      output cmdReady
   );

endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: Depth x Width register file for the sequencer.
//   clk_i, rst_ni          clock, async active-low clear of all entries and captures
//   we_i/waddr_i/wdata_i   single write port (host vs. writeback muxed by the parent)
//   cap_en_i               capture ra/rb reads into rd_a_o/rd_b_o on the next edge
//   ra_addr_i, rb_addr_i   operand read addresses
//   rd_a_o, rd_b_o         registered operands
//   dbg_addr_i/dbg_data_o  combinational debug read
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned  Depth = NREGS,
   parameter int unsigned  Width = WIDTH,
   localparam int unsigned Aw    = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [Aw-1:0]    waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             cap_en_i,
   input  logic [Aw-1:0]    ra_addr_i,
   input  logic [Aw-1:0]    rb_addr_i,
   output logic [Width-1:0] rd_a_o,
   output logic [Width-1:0] rd_b_o,
   input  logic [Aw-1:0]    dbg_addr_i,
   output logic [Width-1:0] dbg_data_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [Width-1:0] rd_a_q, rd_a_d;
   logic [Width-1:0] rd_b_q, rd_b_d;

   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
   end

   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (cap_en_i) begin
         rd_a_d = mem_q[ra_addr_i];
         rd_b_d = mem_q[rb_addr_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '{default: '0};
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         mem_q  <= mem_d;
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign rd_a_o     = rd_a_q;
   assign rd_b_o     = rd_b_q;
   assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side controller for an external combinational 16-bit ALU.
// Each accepted command runs IDLE(accept) -> READ -> EXEC -> WRITE, one command per 4 clocks.
//   clk, reset_n               clock, async active-low reset
//   cmd (alu_sequencer_if)     command handshake, slave side
//   hostWe/hostAddr/hostData   direct register write, honoured only in IDLE
//   rdAddr/rdData              combinational debug read
//   aluOp/aluA/aluB            to ALU; aluY/aluZ/aluC from ALU
//   done                       one-cycle pulse in WRITE
//   flagZ/flagC                registered status flags
//   busy                       high outside IDLE
// Optional (ALU_SEQ_PERF_EN): cntClr in, cmdCount[15:0] out counting done pulses.
module alu_sequencer #(
   parameter int unsigned  NREGS = alu_pkg::NREGS,
   parameter int unsigned  WIDTH = alu_pkg::WIDTH,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   alu_sequencer_if.slave   cmd,
   input  logic             hostWe,
   input  logic [AW-1:0]    hostAddr,
   input  logic [WIDTH-1:0] hostData,
   input  logic [AW-1:0]    rdAddr,
   output logic [WIDTH-1:0] rdData,
   output logic [2:0]       aluOp,
   output logic [WIDTH-1:0] aluA,
   output logic [WIDTH-1:0] aluB,
   input  logic [WIDTH-1:0] aluY,
   input  logic             aluZ,
   input  logic             aluC,
   output logic             done,
   output logic             flagZ,
   output logic             flagC,
   output logic             busy
`ifdef ALU_SEQ_PERF_EN
   ,
   input  logic             cntClr,
   output logic [15:0]      cmdCount
`endif
);

   alu_pkg::state_e state_q, state_d;

   logic [2:0]       op_sel_q, op_sel_d;
   logic [AW-1:0]    src_a_q, src_a_d;
   logic [AW-1:0]    src_b_q, src_b_d;
   logic [AW-1:0]    dst_q, dst_d;
   logic [WIDTH-1:0] res_y_q, res_y_d;
   logic             z_s_q, z_s_d;
   logic             c_s_q, c_s_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_c_q, flag_c_d;

   logic             cmd_accept;
   logic             host_wr;
   logic             wb_wr;
   logic             rf_we;
   logic [AW-1:0]    rf_waddr;
   logic [WIDTH-1:0] rf_wdata;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= alu_pkg::S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         alu_pkg::S_IDLE:  if (cmd_accept) state_d = alu_pkg::S_READ;
         alu_pkg::S_READ:  state_d = alu_pkg::S_EXEC;
         alu_pkg::S_EXEC:  state_d = alu_pkg::S_WRITE;
         alu_pkg::S_WRITE: state_d = alu_pkg::S_IDLE;
         default:          state_d = alu_pkg::S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      cmd.cmdReady = 1'b0;
      done         = 1'b0;
      busy         = 1'b1;
      unique case (state_q)
         alu_pkg::S_IDLE: begin
            busy         = 1'b0;
            // Host writes win the cycle; ready also stays low while reset is held.
            cmd.cmdReady = reset_n & ~hostWe;
         end
         alu_pkg::S_WRITE: done = 1'b1;
         default: ;
      endcase
   end

   assign cmd_accept = cmd.cmdValid & cmd.cmdReady;

   // ---------------- Datapath next state ----------------
   always_comb begin
      op_sel_d = op_sel_q;
      src_a_d  = src_a_q;
      src_b_d  = src_b_q;
      dst_d    = dst_q;
      res_y_d  = res_y_q;
      z_s_d    = z_s_q;
      c_s_d    = c_s_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;

      if (cmd_accept) begin
         op_sel_d = cmd.cmdOp;
         src_a_d  = cmd.cmdSrcA;
         src_b_d  = cmd.cmdSrcB;
         dst_d    = cmd.cmdDst;
      end

      if (state_q == alu_pkg::S_EXEC) begin
         res_y_d = aluY;
         z_s_d   = aluZ;
         c_s_d   = aluC;
      end

      if (state_q == alu_pkg::S_WRITE) begin
         flag_z_d = z_s_q;
         if (alu_pkg::op_sets_carry(op_sel_q)) begin
            flag_c_d = c_s_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_sel_q <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
         dst_q    <= '0;
         res_y_q  <= '0;
         z_s_q    <= 1'b0;
         c_s_q    <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else begin
         op_sel_q <= op_sel_d;
         src_a_q  <= src_a_d;
         src_b_q  <= src_b_d;
         dst_q    <= dst_d;
         res_y_q  <= res_y_d;
         z_s_q    <= z_s_d;
         c_s_q    <= c_s_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
      end
   end

   // ---------------- Register file ----------------
   // Host writes only happen in IDLE and writeback only in WRITE, so they never collide.
   assign host_wr  = hostWe & (state_q == alu_pkg::S_IDLE);
   assign wb_wr    = (state_q == alu_pkg::S_WRITE);
   assign rf_we    = host_wr | wb_wr;
   assign rf_waddr = wb_wr ? dst_q : hostAddr;
   assign rf_wdata = wb_wr ? res_y_q : hostData;

   alu_regfile #(
      .Depth (NREGS),
      .Width (WIDTH)
   ) u_regfile (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .we_i       (rf_we),
      .waddr_i    (rf_waddr),
      .wdata_i    (rf_wdata),
      .cap_en_i   (state_q == alu_pkg::S_READ),
      .ra_addr_i  (src_a_q),
      .rb_addr_i  (src_b_q),
      .rd_a_o     (op_a),
      .rd_b_o     (op_b),
      .dbg_addr_i (rdAddr),
      .dbg_data_o (rdData)
   );

   // Operand registers only change in READ/accept, so the ALU inputs hold steady through EXEC.
   assign aluA  = op_a;
   assign aluB  = op_b;
   assign aluOp = op_sel_q;
   assign flagZ = flag_z_q;
   assign flagC = flag_c_q;

`ifdef ALU_SEQ_PERF_EN
   logic [15:0] cmd_count_q, cmd_count_d;

   always_comb begin
      cmd_count_d = cmd_count_q;
      if (cntClr) begin
         cmd_count_d = '0;
      end else if (done) begin
         cmd_count_d = cmd_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_count_q <= '0;
      end else begin
         cmd_count_q <= cmd_count_d;
      end
   end

   assign cmdCount = cmd_count_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed commands, expected results queued at issue time and
// checked by an independent monitor on every done pulse. A simple ALU model sits outside
// the DUT; it reports C=0 for shl/ror so a wrongly updated flagC is visible.
module tb_alu_sequencer;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SHL = 3'b010, ROR = 3'b011;
   localparam logic [2:0] AND = 3'b100, OR_ = 3'b101, XOR = 3'b110, NOT = 3'b111;

   typedef struct {
      logic [2:0]  dst;
      logic [15:0] y;
      logic        z;
      logic        c;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        hostWe;
   logic [2:0]  hostAddr;
   logic [15:0] hostData;
   logic [2:0]  rdAddr;
   logic [15:0] rdData;
   logic [2:0]  aluOp;
   logic [15:0] aluA, aluB, aluY;
   logic        aluZ, aluC;
   logic        done, flagZ, flagC, busy;
`ifdef ALU_SEQ_PERF_EN
   logic        cntClr;
   logic [15:0] cmdCount;
`endif

   logic [2:0]  main_addr;
   logic [2:0]  mon_addr;
   logic        mon_sel;
   int          cyc;
   int          checks;
   int          failures;
   exp_t        exp_q[$];

   assign rdAddr = mon_sel ? mon_addr : main_addr;

   alu_sequencer_if intf ();

   alu_sequencer u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cmd      (intf.slave),
      .hostWe   (hostWe),
      .hostAddr (hostAddr),
      .hostData (hostData),
      .rdAddr   (rdAddr),
      .rdData   (rdData),
      .aluOp    (aluOp),
      .aluA     (aluA),
      .aluB     (aluB),
      .aluY     (aluY),
      .aluZ     (aluZ),
      .aluC     (aluC),
      .done     (done),
      .flagZ    (flagZ),
      .flagC    (flagC),
      .busy     (busy)
`ifdef ALU_SEQ_PERF_EN
      ,
      .cntClr   (cntClr),
      .cmdCount (cmdCount)
`endif
   );

   // External ALU model
   always_comb begin
      aluY = '0;
      aluC = 1'b0;
      case (aluOp)
         ADD: {aluC, aluY} = {1'b0, aluA} + {1'b0, aluB};
         SUB: begin aluY = aluA - aluB; aluC = (aluA < aluB); end
         SHL: aluY = {aluA[14:0], 1'b0};
         ROR: aluY = {aluA[0], aluA[15:1]};
         AND: aluY = aluA & aluB;
         OR_: aluY = aluA | aluB;
         XOR: aluY = aluA ^ aluB;
         default: aluY = ~aluA;
      endcase
      aluZ = (aluY == 16'h0000);
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input logic [15:0] ey, input logic ez,
                        input logic ec, input bit push, output int acc);
      int n;
      n = 0;
      intf.cmdValid = 1'b1;
      intf.cmdOp    = op;
      intf.cmdSrcA  = a;
      intf.cmdSrcB  = b;
      intf.cmdDst   = d;
      #1;
      while (!intf.cmdReady && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!intf.cmdReady) begin
         check("accept_timeout", 32'(intf.cmdReady), 32'd1);
         intf.cmdValid = 1'b0;
         acc = -1;
         @(negedge clk);
         return;
      end
      acc = cyc + 1;
      if (push) exp_q.push_back('{d, ey, ez, ec, acc});
      @(posedge clk);
      #1;
      intf.cmdValid = 1'b0;
      @(negedge clk);
   endtask

   task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
      hostWe   = 1'b1;
      hostAddr = addr;
      hostData = data;
      @(negedge clk);
      hostWe   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_sel) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Monitor: on each done pulse, pop the expected entry, check latency, then the
   // written register and flags once WRITE has completed.
   initial begin
      exp_t e;
      mon_sel  = 1'b0;
      mon_addr = '0;
      forever begin
         @(negedge clk);
         if (reset_n && done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               // accept edge, READ->EXEC edge, EXEC->WRITE edge: done in the 4th clock
               check("done_latency", 32'(cyc - e.acc), 32'd2);
               mon_addr = e.dst;
               mon_sel  = 1'b1;
               @(negedge clk);
               #1;
               check("done_width", 32'(done), 32'd0);
               check("rf_result", 32'(rdData), 32'(e.y));
               check("flag_z", 32'(flagZ), 32'(e.z));
               check("flag_c", 32'(flagC), 32'(e.c));
               mon_sel = 1'b0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, k;
      cyc           = 0;
      checks        = 0;
      failures      = 0;
      reset_n       = 1'b0;
      hostWe        = 1'b0;
      hostAddr      = '0;
      hostData      = '0;
      main_addr     = '0;
      intf.cmdValid = 1'b0;
      intf.cmdOp    = '0;
      intf.cmdSrcA  = '0;
      intf.cmdSrcB  = '0;
      intf.cmdDst   = '0;
`ifdef ALU_SEQ_PERF_EN
      cntClr        = 1'b0;
`endif

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_flags", {30'd0, flagZ, flagC}, 32'd0);
      check("rst_ready_held", 32'(intf.cmdReady), 32'd0);
      reset_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(intf.cmdReady), 32'd1);
      @(negedge clk);

      // Add with carry: 0xFFFF + 0x0001 -> 0x0000, Z=1, C=1
      host_write(3'd1, 16'hFFFF);
      host_write(3'd2, 16'h0001);
      issue(ADD, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b1, 1'b1, acc1);
      drain();

      // Carry hold across shl / ror
      issue(SHL, 3'd1, 3'd0, 3'd7, 16'hFFFE, 1'b0, 1'b1, 1'b1, acc1);
      drain();
      issue(ROR, 3'd2, 3'd0, 3'd6, 16'h8000, 1'b0, 1'b1, 1'b1, acc1);
      drain();

      // Reset in the middle of EXEC
      issue(ADD, 3'd1, 3'd2, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, acc1);
      @(negedge clk);
      #1;
      check("exec_busy", 32'(busy), 32'd1);
      check("exec_aluA", 32'(aluA), 32'h0000FFFF);
      check("exec_aluB", 32'(aluB), 32'h00000001);
      check("exec_aluOp", 32'(aluOp), 32'(ADD));
      reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_flags", {30'd0, flagZ, flagC}, 32'd0);
      check("midrst_aluA", 32'(aluA), 32'd0);
      for (int i = 0; i < 8; i++) begin
         main_addr = 3'(i);
         #1;
         check("midrst_rf", 32'(rdData), 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check("idle_after_rst", 32'(busy), 32'd0);
      @(negedge clk);

      // Subtract with dst == srcA, then back-to-back AND reading the new value
      host_write(3'd2, 16'h0001);
      host_write(3'd4, 16'h0005);
      host_write(3'd5, 16'h0003);
      issue(SUB, 3'd4, 3'd5, 3'd4, 16'h0002, 1'b0, 1'b0, 1'b1, acc1);
      issue(AND, 3'd4, 3'd4, 3'd6, 16'h0002, 1'b0, 1'b0, 1'b1, acc2);
      check("back_to_back", 32'(acc2 - acc1), 32'd4);
      drain();

      // Host write while busy is dropped
      issue(OR_, 3'd4, 3'd4, 3'd7, 16'h0002, 1'b0, 1'b0, 1'b1, acc1);
      host_write(3'd2, 16'hBEEF);
      drain();
      main_addr = 3'd2;
      #1;
      check("busy_hostwe_ignored", 32'(rdData), 32'h00000001);

      // hostWe has priority over a pending command in IDLE
      k             = cyc;
      hostWe        = 1'b1;
      hostAddr      = 3'd0;
      hostData      = 16'h1234;
      intf.cmdValid = 1'b1;
      intf.cmdOp    = XOR;
      intf.cmdSrcA  = 3'd0;
      intf.cmdSrcB  = 3'd2;
      intf.cmdDst   = 3'd5;
      #1;
      check("hostwe_blocks_ready", 32'(intf.cmdReady), 32'd0);
      @(negedge clk);
      hostWe = 1'b0;
      issue(XOR, 3'd0, 3'd2, 3'd5, 16'h1235, 1'b0, 1'b0, 1'b1, acc1);
      check("hostwe_defers", 32'(acc1 - k), 32'd2);
      drain();
      issue(NOT, 3'd5, 3'd0, 3'd1, 16'hEDCA, 1'b0, 1'b0, 1'b1, acc1);
      drain();

`ifdef ALU_SEQ_PERF_EN
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("perf_rst", 32'(cmdCount), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         issue(ADD, 3'd0, 3'd0, 3'd1, 16'h0000, 1'b1, 1'b0, 1'b1, acc1);
      end
      drain();
      check("perf_count3", 32'(cmdCount), 32'd3);
      issue(ADD, 3'd0, 3'd0, 3'd1, 16'h0000, 1'b1, 1'b0, 1'b1, acc1);
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("perf_done_seen", 32'(done), 32'd1);
      cntClr = 1'b1;
      @(negedge clk);
      cntClr = 1'b0;
      #1;
      check("perf_clr_prio", 32'(cmdCount), 32'd0);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
